// File: rtl/timestamped_frame_arbiter.sv
`default_nettype none
// timestamped_frame_arbiter: round-robin merge of NUM_PORTS length-framed,
// timestamped streams onto one output; a grant covers one whole frame.
module timestamped_frame_arbiter #(
  parameter int NUM_PORTS          = 4,
  parameter int DATA_WIDTH         = 8,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int TIMESTAMP_WIDTH    = 72,
  parameter int PORT_ID_WIDTH      = $clog2(NUM_PORTS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                    s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                    s_axis_tready,
  input  logic [NUM_PORTS-1:0]                    s_axis_tlast,
  input  logic [NUM_PORTS*FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
  input  logic [NUM_PORTS-1:0]                    s_axis_frame_length_tvalid,
  output logic [NUM_PORTS-1:0]                    s_axis_frame_length_tready,
  output logic [DATA_WIDTH-1:0]                   m_axis_tdata,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  output logic [FRAME_LENGTH_WIDTH-1:0]           m_axis_frame_length_tdata,
  output logic [PORT_ID_WIDTH-1:0]                m_axis_frame_length_tuser,
  output logic                                    m_axis_frame_length_tvalid,
  input  logic                                    m_axis_frame_length_tready
);

  localparam int TS_BEATS = TIMESTAMP_WIDTH / DATA_WIDTH;
  localparam int CNT_W    = FRAME_LENGTH_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_LENGTH = 2'd1,
    FORWARD     = 2'd2
  } state_t;

  state_t                        state, state_next;
  logic [PORT_ID_WIDTH-1:0]      rr_ptr, grant, winner;
  logic                          found;
  logic [FRAME_LENGTH_WIDTH-1:0] length_reg;
  logic [CNT_W-1:0]              beat_cnt, last_beat;
  logic                          beat_hs;

  // Framing is purely length-driven, so input tlast carries no information.
  logic unused_tlast;
  assign unused_tlast = ^s_axis_tlast;

  assign last_beat = {1'b0, length_reg} + CNT_W'(TS_BEATS - 1);

  // First length requester at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && s_axis_frame_length_tvalid[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        found  = 1'b1;
        winner = PORT_ID_WIDTH'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Outputs are forced low while rst is high so an aborted frame stops at once.
  always_comb begin
    state_next                 = state;
    beat_hs                    = 1'b0;
    s_axis_tready              = '0;
    s_axis_frame_length_tready = '0;
    m_axis_tdata               = '0;
    m_axis_tvalid              = 1'b0;
    m_axis_tlast               = 1'b0;
    m_axis_frame_length_tdata  = '0;
    m_axis_frame_length_tuser  = '0;
    m_axis_frame_length_tvalid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (found) begin
            s_axis_frame_length_tready[winner] = 1'b1;
            state_next = SEND_LENGTH;
          end
        end
        SEND_LENGTH: begin
          m_axis_frame_length_tvalid = 1'b1;
          m_axis_frame_length_tdata  = length_reg;
          m_axis_frame_length_tuser  = grant;
          if (m_axis_frame_length_tready) state_next = FORWARD;
        end
        FORWARD: begin
          m_axis_tdata          = s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tvalid         = s_axis_tvalid[grant];
          s_axis_tready[grant]  = m_axis_tready;
          m_axis_tlast          = (beat_cnt == last_beat);
          beat_hs               = s_axis_tvalid[grant] && m_axis_tready;
          if (beat_hs && (beat_cnt == last_beat)) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant      <= '0;
      length_reg <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= winner;
            length_reg <= s_axis_frame_length_tdata[winner*FRAME_LENGTH_WIDTH +: FRAME_LENGTH_WIDTH];
            rr_ptr     <= (winner == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
          end
        end
        SEND_LENGTH: begin
          if (m_axis_frame_length_tready) beat_cnt <= '0;
        end
        FORWARD: begin
          if (beat_hs) beat_cnt <= beat_cnt + 1'b1;
        end
        default: begin
          rr_ptr     <= '0;
          grant      <= '0;
          length_reg <= '0;
          beat_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timestamped_frame_arbiter.sv
`default_nettype none
// tb_timestamped_frame_arbiter: directed and randomized traffic checked against
// a frame-level round-robin reference model.
module tb_timestamped_frame_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 8;
  localparam int LW  = 16;
  localparam int PW  = 2;
  localparam int TSB = 72 / DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP-1:0]   s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [NP*LW-1:0] s_axis_frame_length_tdata;
  logic [NP-1:0]   s_axis_frame_length_tvalid, s_axis_frame_length_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [LW-1:0]   m_axis_frame_length_tdata;
  logic [PW-1:0]   m_axis_frame_length_tuser;
  logic            m_axis_frame_length_tvalid, m_axis_frame_length_tready;

  always #5 clk = ~clk;

  timestamped_frame_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(LW),
    .TIMESTAMP_WIDTH(72), .PORT_ID_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_frame_length_tdata(s_axis_frame_length_tdata),
    .s_axis_frame_length_tvalid(s_axis_frame_length_tvalid),
    .s_axis_frame_length_tready(s_axis_frame_length_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_frame_length_tdata(m_axis_frame_length_tdata),
    .m_axis_frame_length_tuser(m_axis_frame_length_tuser),
    .m_axis_frame_length_tvalid(m_axis_frame_length_tvalid),
    .m_axis_frame_length_tready(m_axis_frame_length_tready)
  );

  typedef logic [DW-1:0] byte_q_t [$];
  typedef logic [LW-1:0] len_q_t [$];

  byte_q_t drv_data [NP];   // bytes each source still has to offer
  len_q_t  drv_len  [NP];
  byte_q_t exp_data [NP];   // reference model copy, consumed by the output side
  len_q_t  exp_len  [NP];
  int      grant_log [$];

  int  m_ptr, cur_port, cur_left;
  bit  in_frame;
  int  cyc, len_in_cyc;
  bit  prev_mlen_valid;
  int  n_checks, n_pass;
  int  p_svalid, p_mready, p_lready;
  bit  toggle_mode, toggle_val, rst_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic add_frame(input int p, input int len);
    logic [DW-1:0] b;
    drv_len[p].push_back(LW'(len));
    exp_len[p].push_back(LW'(len));
    for (int i = 0; i < len + TSB; i++) begin
      b = DW'($urandom);
      drv_data[p].push_back(b);
      exp_data[p].push_back(b);
    end
  endtask

  // Round-robin rule: first port at or after the pointer with a pending frame.
  function automatic int predict();
    for (int i = 0; i < NP; i++) begin
      int p = (m_ptr + i) % NP;
      if (exp_len[p].size() > 0) return p;
    end
    return -1;
  endfunction

  task automatic drive();
    rst = rst_req;
    for (int p = 0; p < NP; p++) begin
      s_axis_frame_length_tvalid[p] = drv_len[p].size() > 0;
      s_axis_frame_length_tdata[p*LW +: LW] = (drv_len[p].size() > 0) ? drv_len[p][0] : '0;
      s_axis_tvalid[p] = (drv_data[p].size() > 0) && ($urandom_range(99) < p_svalid);
      s_axis_tdata[p*DW +: DW] = (drv_data[p].size() > 0) ? drv_data[p][0] : DW'($urandom);
      s_axis_tlast[p] = 1'($urandom);
    end
    if (toggle_mode) begin
      toggle_val    = ~toggle_val;
      m_axis_tready = toggle_val;
    end else begin
      m_axis_tready = $urandom_range(99) < p_mready;
    end
    m_axis_frame_length_tready = $urandom_range(99) < p_lready;
  endtask

  task automatic monitor();
    logic [NP-1:0] allowed;
    cyc++;
    if (rst) begin
      prev_mlen_valid = 1'b0;
      return;
    end
    for (int p = 0; p < NP; p++) begin
      if (s_axis_frame_length_tvalid[p] && s_axis_frame_length_tready[p]) begin
        drv_len[p].delete(0);
        len_in_cyc = cyc;
      end
      if (s_axis_tvalid[p] && s_axis_tready[p]) drv_data[p].delete(0);
    end
    allowed = '0;
    if (in_frame) allowed[cur_port] = 1'b1;
    chk("stray_tready", 32'(s_axis_tready & ~allowed), 0);
    if (in_frame) chk("tready_mirror", 32'(s_axis_tready[cur_port]), 32'(m_axis_tready));
    if (m_axis_frame_length_tvalid && !prev_mlen_valid) chk("len_latency", cyc - len_in_cyc, 1);
    prev_mlen_valid = m_axis_frame_length_tvalid;
    if (m_axis_frame_length_tvalid && m_axis_frame_length_tready) begin
      int w = predict();
      chk("len_while_in_frame", 32'(in_frame), 0);
      chk("len_tuser", 32'(m_axis_frame_length_tuser), w);
      if (w >= 0) begin
        chk("len_tdata", 32'(m_axis_frame_length_tdata), 32'(exp_len[w][0]));
        cur_left = int'(exp_len[w][0]) + TSB;
        exp_len[w].delete(0);
        grant_log.push_back(w);
        m_ptr    = (w + 1) % NP;
        cur_port = w;
        in_frame = 1'b1;
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      chk("beat_in_frame", 32'(in_frame), 1);
      if (in_frame && exp_data[cur_port].size() > 0) begin
        chk("beat_data", 32'(m_axis_tdata), 32'(exp_data[cur_port][0]));
        chk("beat_tlast", 32'(m_axis_tlast), 32'(cur_left == 1));
        exp_data[cur_port].delete(0);
        cur_left--;
        if (cur_left == 0) in_frame = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  function automatic bit busy();
    bit b = in_frame;
    for (int p = 0; p < NP; p++) if (exp_len[p].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(busy()), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ctl"}, 32'({s_axis_tready, s_axis_frame_length_tready, m_axis_tvalid,
                           m_axis_tlast, m_axis_frame_length_tvalid}), 0);
    chk({tag, "_dat"}, 32'({m_axis_tdata, m_axis_frame_length_tdata, m_axis_frame_length_tuser}), 0);
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    for (int p = 0; p < NP; p++) begin
      drv_data[p].delete(); drv_len[p].delete();
      exp_data[p].delete(); exp_len[p].delete();
    end
    m_ptr = 0; in_frame = 1'b0; cur_left = 0;
    repeat (n) begin
      step();
      check_quiet("in_reset");
    end
    rst_req = 1'b0;
    step();
    check_quiet("after_reset");
  endtask

  task automatic check_order(input string tag, input int exp_order [$]);
    chk({tag, "_count"}, grant_log.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < grant_log.size(); i++)
      chk(tag, grant_log[i], exp_order[i]);
  endtask

  initial begin
    int n;
    int w;
    rst = 1'b1; rst_req = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    s_axis_frame_length_tdata = '0; s_axis_frame_length_tvalid = '0;
    m_axis_tready = 1'b0; m_axis_frame_length_tready = 1'b0;
    p_svalid = 100; p_mready = 100; p_lready = 100;
    toggle_mode = 1'b0; toggle_val = 1'b0;
    cyc = 0; len_in_cyc = 0; prev_mlen_valid = 1'b0;
    n_checks = 0; n_pass = 0; m_ptr = 0; cur_port = 0; cur_left = 0; in_frame = 1'b0;

    do_reset(2);

    // Single frame on port 1, then ports 1 and 3 contending with the pointer at 2.
    grant_log.delete();
    add_frame(1, 3);
    wait_idle(100);
    for (int k = 0; k < 3; k++) begin
      add_frame(1, $urandom_range(0, 4));
      add_frame(3, $urandom_range(0, 4));
    end
    wait_idle(300);
    check_order("rr_alt", '{1, 3, 1, 3, 1, 3, 1});

    // All four ports present at once straight after reset.
    do_reset(1);
    grant_log.delete();
    add_frame(0, 2); add_frame(1, 4); add_frame(2, 1); add_frame(3, 0);
    wait_idle(200);
    check_order("rr_all", '{0, 1, 2, 3});

    // Output ready toggling every cycle through a short frame.
    toggle_mode = 1'b1;
    add_frame(2, 5);
    wait_idle(200);
    toggle_mode = 1'b0;

    // Length output stalled: everything must hold steady.
    p_lready = 0;
    add_frame(0, 3);
    n = 0;
    while (!m_axis_frame_length_tvalid && n < 20) begin step(); n++; end
    chk("hold_reach", 32'(m_axis_frame_length_tvalid), 1);
    w = predict();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_valid", 32'(m_axis_frame_length_tvalid), 1);
      chk("hold_tuser", 32'(m_axis_frame_length_tuser), w);
      chk("hold_tdata", 32'(m_axis_frame_length_tdata), 3);
      chk("hold_sready", 32'(s_axis_tready), 0);
    end
    p_lready = 100;
    wait_idle(100);

    // Randomized traffic with backpressure on every interface.
    for (int r = 0; r < 4; r++) begin
      p_svalid = 70; p_mready = 60; p_lready = 60;
      for (int p = 0; p < NP; p++)
        repeat ($urandom_range(0, 3)) add_frame(p, $urandom_range(0, 6));
      wait_idle(3000);
    end
    p_svalid = 100; p_mready = 100; p_lready = 100;

    // Reset at beat 4 of 12 on port 2, then ports 2 and 3 contend.
    add_frame(2, 3);
    n = 0;
    while (!(in_frame && cur_left == 9) && n < 50) begin step(); n++; end
    chk("abort_reach", 32'(cur_left), 9);
    do_reset(1);
    grant_log.delete();
    add_frame(2, 2); add_frame(3, 1);
    wait_idle(200);
    check_order("post_reset", '{2, 3});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
